// File: rtl/sprite_bounce.sv
// Sprite position controller: once per frame steps the sprite by SPEED on each
// axis and reflects its direction of travel at the screen edges.
module sprite_bounce #(
  parameter int CORDW    = 16,
  parameter int H_RES    = 480,
  parameter int V_RES    = 272,
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 64,
  parameter int SPX_INIT = 32,
  parameter int SPY_INIT = 16,
  parameter int SPEED    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    run,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic                    dir_x,
  output logic                    dir_y,
  output logic                    moved
);

  localparam int unsigned EXTW = CORDW + 1;

  localparam logic signed [EXTW-1:0]  XMAX_S = EXTW'(H_RES - SPR_W);
  localparam logic signed [EXTW-1:0]  YMAX_S = EXTW'(V_RES - SPR_H);
  localparam logic signed [EXTW-1:0]  SPD_S  = EXTW'(SPEED);
  localparam logic signed [EXTW-1:0]  ZERO_S = '0;
  localparam logic signed [CORDW-1:0] XMAX_C = CORDW'(H_RES - SPR_W);
  localparam logic signed [CORDW-1:0] YMAX_C = CORDW'(V_RES - SPR_H);
  localparam logic signed [CORDW-1:0] XINI_C = CORDW'(SPX_INIT);
  localparam logic signed [CORDW-1:0] YINI_C = CORDW'(SPY_INIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC_X = 2'd1;
  localparam logic [1:0] CALC_Y = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic signed [CORDW-1:0] nx_r;
  logic signed [CORDW-1:0] ny_r;
  logic                    ndx_r;
  logic                    ndy_r;

  logic signed [EXTW-1:0]  nx_c;
  logic signed [EXTW-1:0]  ny_c;
  logic signed [CORDW-1:0] nx_lim_c;
  logic signed [CORDW-1:0] ny_lim_c;
  logic                    ndx_c;
  logic                    ndy_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; frames outside IDLE are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame && run) state_nxt = CALC_X;
      CALC_X:  state_nxt = CALC_Y;
      CALC_Y:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Horizontal step with edge clamp and reflection, one bit of headroom
  always_comb begin
    nx_c     = dir_x ? (EXTW'(sprx) - SPD_S) : (EXTW'(sprx) + SPD_S);
    nx_lim_c = CORDW'(nx_c);
    ndx_c    = dir_x;
    if (nx_c >= XMAX_S) begin
      nx_lim_c = XMAX_C;
      ndx_c    = 1'b1;
    end else if (nx_c <= ZERO_S) begin
      nx_lim_c = '0;
      ndx_c    = 1'b0;
    end
  end

  // Vertical step, same rule as horizontal
  always_comb begin
    ny_c     = dir_y ? (EXTW'(spry) - SPD_S) : (EXTW'(spry) + SPD_S);
    ny_lim_c = CORDW'(ny_c);
    ndy_c    = dir_y;
    if (ny_c >= YMAX_S) begin
      ny_lim_c = YMAX_C;
      ndy_c    = 1'b1;
    end else if (ny_c <= ZERO_S) begin
      ny_lim_c = '0;
      ndy_c    = 1'b0;
    end
  end

  // Intermediate results, held until COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      nx_r  <= XINI_C;
      ny_r  <= YINI_C;
      ndx_r <= 1'b0;
      ndy_r <= 1'b0;
    end else begin
      if (state == CALC_X) begin
        nx_r  <= nx_lim_c;
        ndx_r <= ndx_c;
      end
      if (state == CALC_Y) begin
        ny_r  <= ny_lim_c;
        ndy_r <= ndy_c;
      end
    end
  end

  // Visible outputs only change on COMMIT so they stay stable for a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sprx  <= XINI_C;
      spry  <= YINI_C;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      moved <= 1'b0;
    end else begin
      moved <= (state == COMMIT);
      if (state == COMMIT) begin
        sprx  <= nx_r;
        spry  <= ny_r;
        dir_x <= ndx_r;
        dir_y <= ndy_r;
      end
    end
  end

endmodule

// File: tb/tb_sprite_bounce.sv
// Directed bench for sprite_bounce: reset, stepping, run gating, reset mid-update,
// and edge reflection on a second instance placed near the walls.
module tb_sprite_bounce;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic frame_a = 1'b0;
  logic frame_b = 1'b0;

  logic signed [15:0] sprx_a, spry_a, sprx_b, spry_b;
  logic dir_x_a, dir_y_a, moved_a, dir_x_b, dir_y_b, moved_b;

  int checks = 0;
  int errors = 0;
  int moved_seen;

  always #5 clk = ~clk;

  sprite_bounce #(.SPEED(4)) dut_a (
    .clk(clk), .rst(rst), .frame(frame_a), .run(run),
    .sprx(sprx_a), .spry(spry_a), .dir_x(dir_x_a), .dir_y(dir_y_a), .moved(moved_a)
  );

  // YMAX = 206 here so the vertical walk lands on 2 before the top edge
  sprite_bounce #(.SPEED(4), .V_RES(270), .SPX_INIT(414), .SPY_INIT(202)) dut_b (
    .clk(clk), .rst(rst), .frame(frame_b), .run(run),
    .sprx(sprx_b), .spry(spry_b), .dir_x(dir_x_b), .dir_y(dir_y_b), .moved(moved_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame_b_step();
    frame_b = 1'b1;
    tick();
    frame_b = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_sprx", int'(sprx_a), 32);
    check("rst_spry", int'(spry_a), 16);
    check("rst_dirx", int'(dir_x_a), 0);
    check("rst_diry", int'(dir_y_a), 0);
    check("rst_moved", int'(moved_a), 0);

    // Single step with latency and one-cycle moved pulse
    run = 1'b1;
    frame_a = 1'b1;
    tick();
    frame_a = 1'b0;
    tick();
    tick();
    check("lat_sprx_hold", int'(sprx_a), 32);
    check("lat_moved_low", int'(moved_a), 0);
    tick();
    check("step_sprx", int'(sprx_a), 36);
    check("step_spry", int'(spry_a), 20);
    check("step_moved", int'(moved_a), 1);
    tick();
    check("step_moved_end", int'(moved_a), 0);

    // run low: frames ignored
    run = 1'b0;
    moved_seen = 0;
    for (int i = 0; i < 10; i++) begin
      frame_a = 1'b1;
      tick();
      frame_a = 1'b0;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (moved_a) moved_seen++;
      end
    end
    check("norun_sprx", int'(sprx_a), 36);
    check("norun_spry", int'(spry_a), 20);
    check("norun_moved", moved_seen, 0);

    // Reset while in CALC_Y discards the update
    run = 1'b1;
    frame_a = 1'b1;
    tick();
    frame_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sprx", int'(sprx_a), 32);
    check("midrst_spry", int'(spry_a), 16);
    check("midrst_moved", int'(moved_a), 0);
    moved_seen = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (moved_a) moved_seen++;
    end
    check("midrst_no_pulse", moved_seen, 0);
    check("midrst_sprx_idle", int'(sprx_a), 32);

    // Frame during CALC_X is ignored: exactly one update
    frame_a = 1'b1;
    tick();
    tick();
    frame_a = 1'b0;
    tick();
    tick();
    check("ovl_sprx", int'(sprx_a), 36);
    check("ovl_moved", int'(moved_a), 1);
    moved_seen = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (moved_a) moved_seen++;
    end
    check("ovl_single_sprx", int'(sprx_a), 36);
    check("ovl_single_spry", int'(spry_a), 20);
    check("ovl_no_second", moved_seen, 0);

    // Right edge overshoot clamps; bottom edge exact hit flips
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b_rst_sprx", int'(sprx_b), 414);
    frame_b_step();
    check("edge_sprx", int'(sprx_b), 416);
    check("edge_dirx", int'(dir_x_b), 1);
    check("edge_spry", int'(spry_b), 206);
    check("edge_diry", int'(dir_y_b), 1);
    frame_b_step();
    check("back_sprx", int'(sprx_b), 412);
    check("back_spry", int'(spry_b), 202);

    // Walk up to spry=2, then top edge overshoot
    for (int i = 0; i < 50; i++) frame_b_step();
    check("walk_spry", int'(spry_b), 2);
    check("walk_sprx", int'(sprx_b), 212);
    check("walk_diry", int'(dir_y_b), 1);
    frame_b_step();
    check("top_spry", int'(spry_b), 0);
    check("top_diry", int'(dir_y_b), 0);
    check("top_sprx", int'(sprx_b), 208);
    frame_b_step();
    check("down_spry", int'(spry_b), 4);
    check("down_diry", int'(dir_y_b), 0);
    check("down_dirx", int'(dir_x_b), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
